// File: rtl/cordic_engine.sv
// ---------------------------------------------------------------------------
// cordic_engine
//   One pipelined processing element of a rotation-mode CORDIC sine/cosine
//   chain. Each valid sample gets one micro-rotation by atan(2^-i):
//     x' = x - d*(y >>> i),  y' = y + d*(x >>> i),  alpha' = alpha - d*atan
//   where d = +1 for alpha >= 0, else -1. The quadrant tag is passed through
//   untouched for the post-processing stage.
//
// Ports
//   i_clk        : clock, all state updates on the rising edge
//   i_rst_n      : synchronous reset, ACTIVE-HIGH despite the name
//   in_x/in_y    : signed x/y components (Q.14 fixed point)
//   in_alpha     : signed residual angle (radians, Q.14)
//   in_atan      : atan(2^-i_count), non-negative
//   i_count      : stage index i, used as the arithmetic shift amount
//   i_quadrant   : quadrant tag, carried through
//   valid_in     : input sample valid
//   out_x/out_y  : registered rotated x/y
//   out_alpha    : registered updated residual angle
//   out_quadrant : registered quadrant tag
//   valid_out    : registered output valid (1-cycle latency)
// ---------------------------------------------------------------------------
module cordic_engine #(
    parameter  int DATA_WIDTH = 18,
    parameter  int N_PE       = 15,
    localparam int CW         = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [DATA_WIDTH-1:0] in_alpha,
    input  logic [DATA_WIDTH-1:0] in_atan,
    input  logic [CW-1:0]         i_count,
    input  logic [1:0]            i_quadrant,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_alpha,
    output logic [1:0]            out_quadrant,
    output logic                  valid_out
);

    logic signed [DATA_WIDTH-1:0] w_x_sh;
    logic signed [DATA_WIDTH-1:0] w_y_sh;
    logic                         w_neg;
    logic [DATA_WIDTH-1:0]        w_x_next;
    logic [DATA_WIDTH-1:0]        w_y_next;
    logic [DATA_WIDTH-1:0]        w_alpha_next;

    logic [DATA_WIDTH-1:0]        r_x;
    logic [DATA_WIDTH-1:0]        r_y;
    logic [DATA_WIDTH-1:0]        r_alpha;
    logic [1:0]                   r_quadrant;
    logic                         r_valid;

    always_comb begin
        // Signed >>> sign-fills, so shifts past the MSB collapse to 0 or -1.
        w_x_sh = $signed(in_x) >>> i_count;
        w_y_sh = $signed(in_y) >>> i_count;
        // Zero angle rotates in the positive direction.
        w_neg  = in_alpha[DATA_WIDTH-1];
        if (w_neg) begin
            w_x_next     = in_x + w_y_sh;
            w_y_next     = in_y - w_x_sh;
            w_alpha_next = in_alpha + in_atan;
        end else begin
            w_x_next     = in_x - w_y_sh;
            w_y_next     = in_y + w_x_sh;
            w_alpha_next = in_alpha - in_atan;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_alpha    <= '0;
            r_quadrant <= '0;
            r_valid    <= 1'b0;
        end else if (valid_in) begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_alpha    <= w_alpha_next;
            r_quadrant <= i_quadrant;
            r_valid    <= 1'b1;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    assign out_x        = r_x;
    assign out_y        = r_y;
    assign out_alpha    = r_alpha;
    assign out_quadrant = r_quadrant;
    assign valid_out    = r_valid;

endmodule

// File: tb/tb_cordic_engine.sv
// ---------------------------------------------------------------------------
// tb_cordic_engine
//   Self-checking bench for cordic_engine. Expected results come from an
//   integer reference model (floor division by 2^i, modular wrap to 18 bits)
//   and from hand-computed constants for the directed cases.
// ---------------------------------------------------------------------------
module tb_cordic_engine;

    localparam int DW   = 18;
    localparam int N_PE = 15;
    localparam int CW   = 4;
    localparam longint MOD = 64'sd1 << DW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_x, in_y, in_alpha, in_atan;
    logic [CW-1:0] count;
    logic [1:0]    quad;
    logic          vin;
    logic [DW-1:0] out_x, out_y, out_alpha;
    logic [1:0]    out_quad;
    logic          vout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (what the outputs should be after the last edge)
    logic [DW-1:0] e_x, e_y, e_a;
    logic [1:0]    e_q;
    logic          e_v;

    cordic_engine #(.DATA_WIDTH(DW), .N_PE(N_PE)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_alpha    (in_alpha),
        .in_atan     (in_atan),
        .i_count     (count),
        .i_quadrant  (quad),
        .valid_in    (vin),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_alpha   (out_alpha),
        .out_quadrant(out_quad),
        .valid_out   (vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sval(input logic [DW-1:0] v);
        return v[DW-1] ? longint'(v) - MOD : longint'(v);
    endfunction

    // floor(v / 2^k), i.e. the mathematical meaning of an arithmetic shift
    function automatic longint floor_pow2(input longint v, input int k);
        longint p;
        if (k >= 40) return (v < 0) ? -1 : 0;
        p = 64'sd1 << k;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    function automatic logic [DW-1:0] wrap(input longint v);
        longint m;
        m = v % MOD;
        if (m < 0) m = m + MOD;
        return DW'(m);
    endfunction

    // Drive one cycle of inputs, advance the reference model to match.
    task automatic step(input logic r, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [DW-1:0] a, input logic [DW-1:0] at,
                        input logic [CW-1:0] c, input logic [1:0] q, input logic v);
        longint sx, sy, sa, d;
        @(negedge clk);
        rst = r; in_x = x; in_y = y; in_alpha = a; in_atan = at;
        count = c; quad = q; vin = v;
        @(posedge clk);
        #1;
        if (r) begin
            e_x = '0; e_y = '0; e_a = '0; e_q = '0; e_v = 1'b0;
        end else if (v) begin
            sx = sval(x); sy = sval(y); sa = sval(a);
            d  = (sa >= 0) ? 1 : -1;
            e_x = wrap(sx - d * floor_pow2(sy, int'(c)));
            e_y = wrap(sy + d * floor_pow2(sx, int'(c)));
            e_a = wrap(sa - d * longint'(at));
            e_q = q;
            e_v = 1'b1;
        end else begin
            e_v = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                 CW'($urandom), 2'($urandom), 1'b1);
            n_checks++;
            if ({out_x, out_y, out_alpha, out_quad, vout} !== {(3*DW+3){1'b0}}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got x=%h y=%h a=%h q=%b v=%b, want all zero",
                         i, out_x, out_y, out_alpha, out_quad, vout);
            end
        end
        step(1'b0, 18'd100, 18'd0, 18'd0, 18'd0, 4'd0, 2'b01, 1'b0);
        n_checks++;
        if (vout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got valid_out=%b, want 0", vout);
        end
        step(1'b0, 18'd100, 18'd0, 18'd0, 18'd0, 4'd0, 2'b01, 1'b1);
        n_checks++;
        if (vout !== 1'b1 || out_x !== 18'd100 || out_y !== 18'd100 || out_quad !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b x=%0d y=%0d q=%b, want v=1 x=100 y=100 q=01",
                     vout, out_x, out_y, out_quad);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 18'd5000, 18'd3000, 18'd20, 18'd7, 4'd1, 2'b11, 1'b1);
        step(1'b1, 18'd6000, 18'd1000, 18'd20, 18'd7, 4'd1, 2'b11, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, out_quad, vout} !== {(3*DW+3){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_midstream: got x=%h y=%h a=%h q=%b v=%b, want all zero",
                     out_x, out_y, out_alpha, out_quad, vout);
        end
    endtask

    task automatic test_pos_stage0();
        step(1'b0, 18'd9949, 18'd0, 18'h03244, 18'h03244, 4'd0, 2'b10, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, out_quad, vout} !== {18'd9949, 18'd9949, 18'd0, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL pos_stage0: got x=%0d y=%0d a=%0d q=%b v=%b, want 9949 9949 0 10 1",
                     out_x, out_y, out_alpha, out_quad, vout);
        end
    endtask

    task automatic test_neg_stage2();
        step(1'b0, 18'd16384, 18'd0, -18'sd1000, 18'd4014, 4'd2, 2'b00, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, vout} !== {18'd16384, -18'sd4096, 18'd3014, 1'b1}) begin
            n_fail++;
            $display("FAIL neg_stage2: got x=%0d y=%0d a=%0d v=%b, want 16384 -4096 3014 1",
                     $signed(out_x), $signed(out_y), $signed(out_alpha), vout);
        end
    endtask

    task automatic test_neg_shift_stage3();
        step(1'b0, -18'sd16384, 18'd8192, 18'd100, 18'd2037, 4'd3, 2'b01, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, vout} !== {-18'sd17408, 18'd6144, -18'sd1937, 1'b1}) begin
            n_fail++;
            $display("FAIL neg_shift_stage3: got x=%0d y=%0d a=%0d v=%b, want -17408 6144 -1937 1",
                     $signed(out_x), $signed(out_y), $signed(out_alpha), vout);
        end
    endtask

    task automatic test_zero_angle();
        step(1'b0, 18'd16384, 18'd0, 18'd0, 18'd1, 4'd14, 2'b00, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, vout} !== {18'd16384, 18'd1, -18'sd1, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_angle: got x=%0d y=%0d a=%0d v=%b, want 16384 1 -1 1",
                     $signed(out_x), $signed(out_y), $signed(out_alpha), vout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom_range(0, 18'h1FFFF)),
                 CW'($urandom_range(0, N_PE - 1)), 2'($urandom), 1'b1);
            n_checks++;
            if ({out_x, out_y, out_alpha, out_quad, vout} !== {e_x, e_y, e_a, e_q, 1'b1}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got x=%h y=%h a=%h q=%b v=%b, want %h %h %h %b 1",
                         i, out_x, out_y, out_alpha, out_quad, vout, e_x, e_y, e_a, e_q);
            end
        end
        // Gap: data changes but outputs must hold the last result.
        step(1'b0, 18'h0AAAA, 18'h15555, 18'h01234, 18'h00100, 4'd1, 2'b11, 1'b0);
        n_checks++;
        if ({out_x, out_y, out_alpha, out_quad, vout} !== {e_x, e_y, e_a, e_q, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_gap: got x=%h y=%h a=%h q=%b v=%b, want %h %h %h %b 0",
                     out_x, out_y, out_alpha, out_quad, vout, e_x, e_y, e_a, e_q);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 18'h1FFFF, 18'h1FFFF, 18'd0, 18'd0, 4'd0, 2'b00, 1'b1);
        n_checks++;
        if ({out_x, out_y, out_alpha, vout} !== {18'h00000, 18'h3FFFE, 18'h00000, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap: got x=%h y=%h a=%h v=%b, want 00000 3fffe 00000 1",
                     out_x, out_y, out_alpha, vout);
        end
    endtask

    task automatic test_random();
        logic r, v;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 75);
            step(r, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom_range(0, 18'h1FFFF)),
                 CW'($urandom_range(0, N_PE - 1)), 2'($urandom), v);
            n_checks++;
            if ({out_x, out_y, out_alpha, out_quad, vout} !== {e_x, e_y, e_a, e_q, e_v}) begin
                n_fail++;
                $display("FAIL random[%0d]: got x=%h y=%h a=%h q=%b v=%b, want %h %h %h %b %b",
                         i, out_x, out_y, out_alpha, out_quad, vout, e_x, e_y, e_a, e_q, e_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0;
        in_x = '0; in_y = '0; in_alpha = '0; in_atan = '0; count = '0; quad = '0;
        e_x = '0; e_y = '0; e_a = '0; e_q = '0; e_v = 1'b0;
        test_reset();
        test_pos_stage0();
        test_neg_stage2();
        test_neg_shift_stage3();
        test_zero_angle();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
